instr_enc: RTL and testbench

Sequential Thumb-subset instruction encoder and program loader. It accepts symbolic instruction requests (opcode, register fields, immediate) over a valid/ready handshake and packs each into the 16-bit encoding that the core's instruction decoder consumes. It writes the encoded words to consecutive instruction-memory addresses and, at end of program, pads with a fixed number of NOPs. It sits between the testbench or boot controller and the instruction-memory write port.

---
 rtl/instr_enc_pkg.sv | 60 ++++++
 rtl/instr_pack.sv | 108 ++++++++++
 rtl/instr_enc.sv | 161 ++++++++++++++++
 tb/tb_instr_enc.sv | 336 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/instr_enc_pkg.sv
// -----------------------------------------------------------------------------
// instr_enc_pkg
// Shared types and constants for the Thumb-subset instruction encoder:
//   enc_op_t     - symbolic mnemonic carried on req_op
//   NOP_WORD     - canonical 16-bit NOP written for pads and rejected requests
//   COND_*       - B.cond condition codes the decoder supports
//   enc_state_t  - loader FSM state
//   cond_supported() - legality test for a B.cond condition field
// -----------------------------------------------------------------------------
package instr_enc_pkg;

    typedef enum logic [4:0] {
        ADD_R  = 5'd0,
        SUB_R  = 5'd1,
        ADD_I3 = 5'd2,
        SUB_I3 = 5'd3,
        MOV_I  = 5'd4,
        AND    = 5'd5,
        EOR    = 5'd6,
        LSL    = 5'd7,
        LSR    = 5'd8,
        ASR    = 5'd9,
        ROR    = 5'd10,
        CMP    = 5'd11,
        ORR    = 5'd12,
        MVN    = 5'd13,
        MOV_R  = 5'd14,
        BX     = 5'd15,
        LDR    = 5'd16,
        STR    = 5'd17,
        ADD_SP = 5'd18,
        SUB_SP = 5'd19,
        BCOND  = 5'd20,
        B      = 5'd21,
        NOP    = 5'd22
    } enc_op_t;

    localparam logic [15:0] NOP_WORD = 16'hBF00;

    localparam logic [3:0] COND_EQ = 4'h0;
    localparam logic [3:0] COND_NE = 4'h1;
    localparam logic [3:0] COND_GE = 4'hA;
    localparam logic [3:0] COND_LT = 4'hB;
    localparam logic [3:0] COND_GT = 4'hC;
    localparam logic [3:0] COND_LE = 4'hD;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_PAD  = 2'd2,
        ST_DONE = 2'd3
    } enc_state_t;

    // The downstream decoder only implements the flag tests listed above.
    function automatic logic cond_supported(input logic [3:0] c);
        return (c == COND_EQ) || (c == COND_NE) || (c == COND_GE) ||
               (c == COND_LT) || (c == COND_GT) || (c == COND_LE);
    endfunction

endpackage

// File: rtl/instr_pack.sv
// -----------------------------------------------------------------------------
// instr_pack
// Combinational packer: turns one symbolic request into its 16-bit encoding.
// Out-of-range immediates, unsupported conditions and undefined opcodes yield
// NOP_WORD with o_illegal raised so the loader can keep addressing dense.
// Ports:
//   i_op          5   enc_op_t mnemonic
//   i_rd/rn/rm    3   register fields (rn also carries the CMP operand)
//   i_imm         16  immediate; two's-complement offset for branches
//   i_cond        4   B.cond condition
//   o_word        16  packed instruction word
//   o_illegal     1   request could not be encoded
// -----------------------------------------------------------------------------
module instr_pack
    import instr_enc_pkg::*;
(
    input  logic [4:0]  i_op,
    input  logic [2:0]  i_rd,
    input  logic [2:0]  i_rn,
    input  logic [2:0]  i_rm,
    input  logic [15:0] i_imm,
    input  logic [3:0]  i_cond,
    output logic [15:0] o_word,
    output logic        o_illegal
);

    enc_op_t            w_op;
    logic signed [15:0] w_simm;
    logic               w_imm3_ok;
    logic               w_imm5_ok;
    logic               w_imm7_ok;
    logic               w_imm8_ok;
    logic               w_bcond_ok;
    logic               w_b_ok;

    assign w_op   = enc_op_t'(i_op);
    assign w_simm = $signed(i_imm);

    assign w_imm3_ok  = (i_imm <= 16'd7);
    assign w_imm5_ok  = (i_imm <= 16'd31);
    assign w_imm7_ok  = (i_imm <= 16'd127);
    assign w_imm8_ok  = (i_imm <= 16'd255);
    // Branch offsets are signed: the field keeps only the low bits, so the
    // full 16-bit value must sign-extend from the field width.
    assign w_bcond_ok = (w_simm >= -16'sd128)  && (w_simm <= 16'sd127) &&
                        cond_supported(i_cond);
    assign w_b_ok     = (w_simm >= -16'sd1024) && (w_simm <= 16'sd1023);

    always_comb begin
        o_word    = NOP_WORD;
        o_illegal = 1'b0;
        case (w_op)
            ADD_R:  o_word = {7'b0001100, i_rm, i_rn, i_rd};
            SUB_R:  o_word = {7'b0001101, i_rm, i_rn, i_rd};
            ADD_I3: begin
                if (w_imm3_ok) o_word = {7'b0001110, i_imm[2:0], i_rn, i_rd};
                else           o_illegal = 1'b1;
            end
            SUB_I3: begin
                if (w_imm3_ok) o_word = {7'b0001111, i_imm[2:0], i_rn, i_rd};
                else           o_illegal = 1'b1;
            end
            MOV_I: begin
                if (w_imm8_ok) o_word = {5'b00100, i_rd, i_imm[7:0]};
                else           o_illegal = 1'b1;
            end
            AND:    o_word = {6'b010000, 4'b0000, i_rm, i_rd};
            EOR:    o_word = {6'b010000, 4'b0001, i_rm, i_rd};
            LSL:    o_word = {6'b010000, 4'b0010, i_rm, i_rd};
            LSR:    o_word = {6'b010000, 4'b0011, i_rm, i_rd};
            ASR:    o_word = {6'b010000, 4'b0100, i_rm, i_rd};
            ROR:    o_word = {6'b010000, 4'b0111, i_rm, i_rd};
            // CMP has no destination; the low field holds the compared Rn.
            CMP:    o_word = {6'b010000, 4'b1010, i_rm, i_rn};
            ORR:    o_word = {6'b010000, 4'b1100, i_rm, i_rd};
            MVN:    o_word = {6'b010000, 4'b1111, i_rm, i_rd};
            MOV_R:  o_word = {8'b01000110, 2'b00, i_rm, i_rd};
            BX:     o_word = {9'b010001110, 1'b0, i_rm, 3'b000};
            LDR: begin
                if (w_imm5_ok) o_word = {5'b01101, i_imm[4:0], i_rn, i_rd};
                else           o_illegal = 1'b1;
            end
            STR: begin
                if (w_imm5_ok) o_word = {5'b01100, i_imm[4:0], i_rn, i_rd};
                else           o_illegal = 1'b1;
            end
            ADD_SP: begin
                if (w_imm7_ok) o_word = {9'b101100000, i_imm[6:0]};
                else           o_illegal = 1'b1;
            end
            SUB_SP: begin
                if (w_imm7_ok) o_word = {9'b101100001, i_imm[6:0]};
                else           o_illegal = 1'b1;
            end
            BCOND: begin
                if (w_bcond_ok) o_word = {4'b1101, i_cond, i_imm[7:0]};
                else            o_illegal = 1'b1;
            end
            B: begin
                if (w_b_ok) o_word = {5'b11100, i_imm[10:0]};
                else        o_illegal = 1'b1;
            end
            NOP:    o_word = NOP_WORD;
            default: o_illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/instr_enc.sv
// -----------------------------------------------------------------------------
// instr_enc
// Sequential instruction encoder / program loader. Accepts symbolic requests
// over valid/ready, packs each one and writes it to consecutive instruction
// memory addresses, then appends PAD_NOPS NOPs and pulses done.
// Parameters:
//   DEPTH     instruction-memory words (AW = $clog2(DEPTH))
//   PAD_NOPS  NOPs appended after the last request (0 allowed)
// Ports:
//   clk, rst_n             clock, asynchronous active-low reset
//   start                  begin a new program at address 0, clear errors
//   req_valid/req_ready    request handshake (ready depends on state/addr only)
//   req_op/rd/rn/rm/imm/cond/last   request fields
//   imem_we/addr/wdata     registered memory write port
//   busy                   FSM not idle
//   done                   one-cycle pulse the cycle after the final write
//   err_imm, err_full      sticky error flags
//   word_count             words written since start
// -----------------------------------------------------------------------------
module instr_enc
    import instr_enc_pkg::*;
#(
    parameter int DEPTH    = 256,
    parameter int PAD_NOPS = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       start,
    input  logic                       req_valid,
    output logic                       req_ready,
    input  logic [4:0]                 req_op,
    input  logic [2:0]                 req_rd,
    input  logic [2:0]                 req_rn,
    input  logic [2:0]                 req_rm,
    input  logic [15:0]                req_imm,
    input  logic [3:0]                 req_cond,
    input  logic                       req_last,
    output logic                       imem_we,
    output logic [$clog2(DEPTH)-1:0]   imem_addr,
    output logic [15:0]                imem_wdata,
    output logic                       busy,
    output logic                       done,
    output logic                       err_imm,
    output logic                       err_full,
    output logic [$clog2(DEPTH):0]     word_count
);

    localparam int AW  = $clog2(DEPTH);
    localparam int PCW = $clog2(PAD_NOPS + 2);
    localparam logic [AW:0]    L_DEPTH = (AW+1)'(DEPTH);
    localparam logic [PCW-1:0] L_PAD   = PCW'(PAD_NOPS);

    enc_state_t     r_state;
    enc_state_t     w_state_nxt;
    logic [AW:0]    r_addr;
    logic [PCW-1:0] r_pad_cnt;
    logic           r_err_imm;
    logic           r_err_full;
    logic           r_vld_p1;
    logic [AW-1:0]  r_waddr_p1;
    logic [15:0]    r_wdata_p1;

    logic           w_room;
    logic           w_accept;
    logic           w_pad_issue;
    logic           w_set_full;
    logic [15:0]    w_pack_word;
    logic           w_pack_illegal;

    instr_pack u_pack (
        .i_op      (req_op),
        .i_rd      (req_rd),
        .i_rn      (req_rn),
        .i_rm      (req_rm),
        .i_imm     (req_imm),
        .i_cond    (req_cond),
        .o_word    (w_pack_word),
        .o_illegal (w_pack_illegal)
    );

    // r_addr is the next address to write and doubles as the word counter.
    assign w_room    = (r_addr < L_DEPTH);
    assign req_ready = (r_state == ST_RUN) && w_room;
    assign w_accept  = req_valid && req_ready;

    always_comb begin
        w_state_nxt = r_state;
        w_pad_issue = 1'b0;
        w_set_full  = 1'b0;
        case (r_state)
            ST_IDLE: ;
            ST_RUN: begin
                if (w_accept) begin
                    if (req_last) w_state_nxt = (PAD_NOPS > 0) ? ST_PAD : ST_DONE;
                end else if (!w_room) begin
                    w_set_full  = 1'b1;
                    w_state_nxt = ST_DONE;
                end
            end
            ST_PAD: begin
                if (!w_room) begin
                    w_set_full  = 1'b1;
                    w_state_nxt = ST_DONE;
                end else begin
                    w_pad_issue = 1'b1;
                    if ((r_pad_cnt + PCW'(1)) == L_PAD) w_state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                // Hold until the final write has left the output register so
                // that done lands on the cycle after it.
                if (!r_vld_p1) w_state_nxt = ST_IDLE;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
        if (start) w_state_nxt = ST_RUN;
    end

    // Stage p0 -> p1: packed word captured into the memory write register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_IDLE;
            r_addr     <= '0;
            r_pad_cnt  <= '0;
            r_err_imm  <= 1'b0;
            r_err_full <= 1'b0;
            r_vld_p1   <= 1'b0;
            r_waddr_p1 <= '0;
            r_wdata_p1 <= NOP_WORD;
        end else begin
            r_state <= w_state_nxt;
            if (start) begin
                r_addr     <= '0;
                r_pad_cnt  <= '0;
                r_err_imm  <= 1'b0;
                r_err_full <= 1'b0;
                r_vld_p1   <= 1'b0;
            end else begin
                r_vld_p1 <= w_accept || w_pad_issue;
                if (w_accept || w_pad_issue) begin
                    r_waddr_p1 <= r_addr[AW-1:0];
                    r_wdata_p1 <= w_accept ? w_pack_word : NOP_WORD;
                    r_addr     <= r_addr + (AW+1)'(1);
                end
                if (w_pad_issue)                r_pad_cnt  <= r_pad_cnt + PCW'(1);
                if (w_accept && w_pack_illegal) r_err_imm  <= 1'b1;
                if (w_set_full)                 r_err_full <= 1'b1;
            end
        end
    end

    assign imem_we    = r_vld_p1;
    assign imem_addr  = r_waddr_p1;
    assign imem_wdata = r_wdata_p1;
    assign busy       = (r_state != ST_IDLE);
    assign done       = (r_state == ST_DONE) && !r_vld_p1;
    assign err_imm    = r_err_imm;
    assign err_full   = r_err_full;
    assign word_count = r_addr;

endmodule

// File: tb/tb_instr_enc.sv
// -----------------------------------------------------------------------------
// tb_instr_enc
// Scoreboard bench: stimulus pushes the expected (address, word) of every write
// into a queue; a monitor pops and compares on each imem_we. A second,
// shallow instance (DEPTH=4) exercises memory exhaustion.
// -----------------------------------------------------------------------------
module tb_instr_enc;
    import instr_enc_pkg::*;

    localparam int DEPTH   = 256;
    localparam int AW      = 8;
    localparam int S_DEPTH = 4;
    localparam int S_AW    = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        start, start_s;
    logic        req_valid, req_valid_s;
    logic [4:0]  req_op;
    logic [2:0]  req_rd, req_rn, req_rm;
    logic [15:0] req_imm;
    logic [3:0]  req_cond;
    logic        req_last;

    logic          req_ready, imem_we, busy, done, err_imm, err_full;
    logic [AW-1:0] imem_addr;
    logic [15:0]   imem_wdata;
    logic [AW:0]   word_count;

    logic            req_ready_s, imem_we_s, busy_s, done_s, err_imm_s, err_full_s;
    logic [S_AW-1:0] imem_addr_s;
    logic [15:0]     imem_wdata_s;
    logic [S_AW:0]   word_count_s;

    instr_enc #(.DEPTH(DEPTH), .PAD_NOPS(2)) u_dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_op(req_op), .req_rd(req_rd), .req_rn(req_rn), .req_rm(req_rm),
        .req_imm(req_imm), .req_cond(req_cond), .req_last(req_last),
        .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
        .busy(busy), .done(done), .err_imm(err_imm), .err_full(err_full),
        .word_count(word_count)
    );

    instr_enc #(.DEPTH(S_DEPTH), .PAD_NOPS(2)) u_small (
        .clk(clk), .rst_n(rst_n), .start(start_s),
        .req_valid(req_valid_s), .req_ready(req_ready_s),
        .req_op(req_op), .req_rd(req_rd), .req_rn(req_rn), .req_rm(req_rm),
        .req_imm(req_imm), .req_cond(req_cond), .req_last(req_last),
        .imem_we(imem_we_s), .imem_addr(imem_addr_s), .imem_wdata(imem_wdata_s),
        .busy(busy_s), .done(done_s), .err_imm(err_imm_s), .err_full(err_full_s),
        .word_count(word_count_s)
    );

    typedef struct packed {
        logic [15:0] addr;
        logic [15:0] data;
    } exp_t;

    exp_t q[$];
    exp_t qs[$];
    int   n_checks = 0;
    int   n_pass   = 0;
    int   done_cnt = 0;
    int   done_cnt_s = 0;
    int   exp_addr = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    // Monitor for the main instance
    always @(negedge clk) begin
        exp_t e;
        if (imem_we === 1'b1) begin
            if (q.size() == 0) begin
                chk("sb_unexpected_write", 32'(q.size()), 32'd1);
            end else begin
                e = q.pop_front();
                chk("sb_addr", 32'(imem_addr), 32'(e.addr));
                chk("sb_data", 32'(imem_wdata), 32'(e.data));
            end
        end
        if (done === 1'b1) done_cnt++;
    end

    // Monitor for the shallow instance
    always @(negedge clk) begin
        exp_t e;
        if (imem_we_s === 1'b1) begin
            if (qs.size() == 0) begin
                chk("small_unexpected_write", 32'(qs.size()), 32'd1);
            end else begin
                e = qs.pop_front();
                chk("small_addr", 32'(imem_addr_s), 32'(e.addr));
                chk("small_data", 32'(imem_wdata_s), 32'(e.data));
            end
        end
        if (done_s === 1'b1) done_cnt_s++;
    end

    task automatic set_req(input logic [4:0] op, input logic [2:0] rd, input logic [2:0] rn,
                           input logic [2:0] rm, input logic [15:0] imm, input logic [3:0] cond,
                           input logic last);
        req_op = op; req_rd = rd; req_rn = rn; req_rm = rm;
        req_imm = imm; req_cond = cond; req_last = last;
    endtask

    // Issue one request to the main instance and record its expected word.
    task automatic send(input logic [4:0] op, input logic [2:0] rd, input logic [2:0] rn,
                        input logic [2:0] rm, input logic [15:0] imm, input logic [3:0] cond,
                        input logic last, input logic [15:0] word);
        int n;
        n = 0;
        set_req(op, rd, rn, rm, imm, cond, last);
        req_valid = 1'b1;
        while (req_ready !== 1'b1 && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        if (req_ready !== 1'b1) begin
            chk("send_ready_timeout", 32'(req_ready), 32'd1);
            req_valid = 1'b0;
            return;
        end
        q.push_back('{addr: 16'(exp_addr), data: word});
        exp_addr++;
        @(posedge clk); #1;
        req_valid = 1'b0;
        req_last  = 1'b0;
    endtask

    task automatic start_prog();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        exp_addr = 0;
    endtask

    // Expect the two pad NOPs, then a single done pulse and the final count.
    task automatic end_prog(input string name, input int words);
        int d0;
        int n;
        d0 = done_cnt;
        n  = 0;
        q.push_back('{addr: 16'(exp_addr), data: NOP_WORD}); exp_addr++;
        q.push_back('{addr: 16'(exp_addr), data: NOP_WORD}); exp_addr++;
        while (done_cnt == d0 && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        chk({name, "_done_pulse"}, 32'(done_cnt - d0), 32'd1);
        chk({name, "_word_count"}, 32'(word_count), 32'(words));
        chk({name, "_sb_drained"}, 32'(q.size()), 32'd0);
    endtask

    task automatic illegal(input string name, input logic [4:0] op, input logic [15:0] imm,
                           input logic [3:0] cond);
        start_prog();
        chk({name, "_err_cleared"}, 32'(err_imm), 32'd0);
        send(op, 3'd1, 3'd2, 3'd3, imm, cond, 1'b1, NOP_WORD);
        chk({name, "_err_imm"}, 32'(err_imm), 32'd1);
        end_prog(name, 3);
    endtask

    logic [4:0]  dp_op [9];
    logic [15:0] dp_w  [9];
    logic [15:0] s_words [4];

    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached, checks %0d/%0d", n_pass, n_checks);
        $fatal(1);
    end

    initial begin
        dp_op   = '{AND, EOR, LSL, LSR, ASR, ROR, CMP, ORR, MVN};
        dp_w    = '{16'h4007, 16'h4047, 16'h4087, 16'h40C7, 16'h4107,
                    16'h41C7, 16'h4287, 16'h4307, 16'h43C7};
        s_words = '{16'h1800, 16'h1809, 16'h1812, 16'h181B};

        rst_n = 1'b0; start = 1'b0; start_s = 1'b0;
        req_valid = 1'b0; req_valid_s = 1'b0;
        set_req(5'd0, 3'd0, 3'd0, 3'd0, 16'd0, 4'd0, 1'b0);

        // Reset values
        #12;
        chk("rst_req_ready",  32'(req_ready),  32'd0);
        chk("rst_imem_we",    32'(imem_we),    32'd0);
        chk("rst_imem_addr",  32'(imem_addr),  32'd0);
        chk("rst_imem_wdata", 32'(imem_wdata), 32'hBF00);
        chk("rst_busy",       32'(busy),       32'd0);
        chk("rst_done",       32'(done),       32'd0);
        chk("rst_err_imm",    32'(err_imm),    32'd0);
        chk("rst_err_full",   32'(err_full),   32'd0);
        chk("rst_word_count", 32'(word_count), 32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("idle_busy", 32'(busy), 32'd0);

        // ADD_R + MOV_I(last) with two pads, exact done timing
        start_prog();
        chk("run_ready", 32'(req_ready), 32'd1);
        send(ADD_R, 3'd1, 3'd2, 3'd3, 16'd0, 4'd0, 1'b0, 16'h18D1);
        send(MOV_I, 3'd0, 3'd0, 3'd0, 16'd5, 4'd0, 1'b1, 16'h2005);
        q.push_back('{addr: 16'd2, data: NOP_WORD});
        q.push_back('{addr: 16'd3, data: NOP_WORD});
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("t1_last_write_we", 32'(imem_we), 32'd1);
        chk("t1_done_early",    32'(done),    32'd0);
        @(posedge clk); #1;
        chk("t1_done",       32'(done),       32'd1);
        chk("t1_we_off",     32'(imem_we),    32'd0);
        chk("t1_word_count", 32'(word_count), 32'd4);
        chk("t1_busy_done",  32'(busy),       32'd1);
        @(posedge clk); #1;
        chk("t1_done_pulse", 32'(done), 32'd0);
        chk("t1_busy_idle",  32'(busy), 32'd0);
        chk("t1_err_imm",    32'(err_imm), 32'd0);
        chk("t1_sb_drained", 32'(q.size()), 32'd0);

        // All data-processing ops; CMP takes its operand from rn
        start_prog();
        for (int i = 0; i < 9; i++) begin
            send(dp_op[i], (i == 6) ? 3'd0 : 3'd7, (i == 6) ? 3'd7 : 3'd0, 3'd0,
                 16'd0, 4'd0, (i == 8), dp_w[i]);
        end
        end_prog("dp", 11);

        // Remaining legal encodings including range edges
        start_prog();
        send(SUB_R,  3'd0, 3'd1, 3'd2, 16'd0,     4'h0, 1'b0, 16'h1A88);
        send(ADD_I3, 3'd4, 3'd3, 3'd0, 16'd7,     4'h0, 1'b0, 16'h1DDC);
        send(SUB_I3, 3'd1, 3'd0, 3'd0, 16'd2,     4'h0, 1'b0, 16'h1E81);
        send(MOV_I,  3'd3, 3'd0, 3'd0, 16'd255,   4'h0, 1'b0, 16'h23FF);
        send(MOV_R,  3'd2, 3'd0, 3'd5, 16'd0,     4'h0, 1'b0, 16'h462A);
        send(BX,     3'd0, 3'd0, 3'd6, 16'd0,     4'h0, 1'b0, 16'h4730);
        send(LDR,    3'd2, 3'd1, 3'd0, 16'd4,     4'h0, 1'b0, 16'h690A);
        send(STR,    3'd7, 3'd7, 3'd0, 16'd31,    4'h0, 1'b0, 16'h67FF);
        send(ADD_SP, 3'd0, 3'd0, 3'd0, 16'd127,   4'h0, 1'b0, 16'hB07F);
        send(SUB_SP, 3'd0, 3'd0, 3'd0, 16'd1,     4'h0, 1'b0, 16'hB081);
        send(BCOND,  3'd0, 3'd0, 3'd0, 16'hFFFE,  4'h1, 1'b0, 16'hD1FE);
        send(BCOND,  3'd0, 3'd0, 3'd0, 16'h007F,  4'hD, 1'b0, 16'hDD7F);
        send(BCOND,  3'd0, 3'd0, 3'd0, 16'hFF80,  4'hA, 1'b0, 16'hDA80);
        send(B,      3'd0, 3'd0, 3'd0, 16'h0004,  4'h0, 1'b0, 16'hE004);
        send(B,      3'd0, 3'd0, 3'd0, 16'hFC00,  4'h0, 1'b0, 16'hE400);
        send(B,      3'd0, 3'd0, 3'd0, 16'h03FF,  4'h0, 1'b0, 16'hE3FF);
        send(NOP,    3'd0, 3'd0, 3'd0, 16'd0,     4'h0, 1'b1, 16'hBF00);
        chk("legal_err_imm", 32'(err_imm), 32'd0);
        end_prog("legal", 19);

        // Illegal requests: each writes a NOP and raises err_imm
        illegal("ill_addi3_8",   ADD_I3, 16'd8,    4'h0);
        illegal("ill_bcond_c2",  BCOND,  16'd0,    4'h2);
        illegal("ill_b_m1025",   B,      16'hFBFF, 4'h0);
        illegal("ill_bcond_128", BCOND,  16'h0080, 4'h0);
        illegal("ill_movi_256",  MOV_I,  16'd256,  4'h0);
        illegal("ill_ldr_32",    LDR,    16'd32,   4'h0);
        illegal("ill_addsp_128", ADD_SP, 16'd128,  4'h0);
        illegal("ill_undef_op",  5'd31,  16'd0,    4'h0);
        chk("main_err_full", 32'(err_full), 32'd0);

        // Shallow memory: six streamed requests, only four fit
        start_s = 1'b1;
        @(posedge clk); #1;
        start_s = 1'b0;
        for (int i = 0; i < 6; i++) begin
            set_req(ADD_R, 3'(i), 3'(i), 3'd0, 16'd0, 4'h0, (i == 5));
            req_valid_s = 1'b1;
            chk("small_ready", 32'(req_ready_s), (i < 4) ? 32'd1 : 32'd0);
            if (i < 4) qs.push_back('{addr: 16'(i), data: s_words[i]});
            @(posedge clk); #1;
        end
        req_valid_s = 1'b0;
        req_last    = 1'b0;
        for (int n = 0; n < 20 && done_cnt_s == 0; n++) begin
            @(posedge clk); #1;
        end
        chk("small_done",       32'(done_cnt_s),   32'd1);
        chk("small_err_full",   32'(err_full_s),   32'd1);
        chk("small_err_imm",    32'(err_imm_s),    32'd0);
        chk("small_word_count", 32'(word_count_s), 32'd4);
        chk("small_busy",       32'(busy_s),       32'd0);
        chk("small_sb_drained", 32'(qs.size()),    32'd0);

        // start while padding: pad write dropped, flags cleared, addr back to 0
        start_prog();
        send(ADD_I3, 3'd0, 3'd0, 3'd0, 16'd8,  4'h0, 1'b0, NOP_WORD);
        send(MOV_I,  3'd1, 3'd0, 3'd0, 16'h12, 4'h0, 1'b1, 16'h2112);
        chk("pad_err_imm_set", 32'(err_imm), 32'd1);
        chk("pad_in_pad_busy", 32'(busy),    32'd1);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        exp_addr = 0;
        chk("restart_we_dropped", 32'(imem_we),    32'd0);
        chk("restart_err_imm",    32'(err_imm),    32'd0);
        chk("restart_word_count", 32'(word_count), 32'd0);
        chk("restart_ready",      32'(req_ready),  32'd1);
        send(ADD_R, 3'd1, 3'd2, 3'd3, 16'd0, 4'h0, 1'b1, 16'h18D1);
        end_prog("restart", 3);

        // Asynchronous reset in the middle of a program
        start_prog();
        send(B,     3'd0, 3'd0, 3'd0, 16'hFBFF, 4'h0, 1'b0, NOP_WORD);
        send(MOV_I, 3'd5, 3'd0, 3'd0, 16'h12,   4'h0, 1'b0, 16'h2512);
        chk("pre_rst_we",      32'(imem_we), 32'd1);
        chk("pre_rst_err_imm", 32'(err_imm), 32'd1);
        q.delete();
        #1 rst_n = 1'b0;
        #1;
        chk("arst_req_ready",  32'(req_ready),  32'd0);
        chk("arst_imem_we",    32'(imem_we),    32'd0);
        chk("arst_imem_addr",  32'(imem_addr),  32'd0);
        chk("arst_imem_wdata", 32'(imem_wdata), 32'hBF00);
        chk("arst_busy",       32'(busy),       32'd0);
        chk("arst_done",       32'(done),       32'd0);
        chk("arst_err_imm",    32'(err_imm),    32'd0);
        chk("arst_err_full",   32'(err_full),   32'd0);
        chk("arst_word_count", 32'(word_count), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("post_rst_idle", 32'(busy), 32'd0);
        chk("final_sb_empty", 32'(q.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
